// File: rtl/kyber_poly_pkg.sv
// rtl/kyber_poly_pkg.sv - shared modes, defaults, FSM type and Barrett constant for the pointwise engine
package kyber_poly_pkg;

  localparam int DEF_COEF_W = 12;
  localparam int DEF_LANES  = 8;
  localparam int DEF_Q      = 3329;

  localparam logic [1:0] MODE_ADD   = 2'd0;
  localparam logic [1:0] MODE_SUB   = 2'd1;
  localparam logic [1:0] MODE_MUL   = 2'd2;
  localparam logic [1:0] MODE_SCALE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // m = floor(2^(2*coef_w) / q), evaluated at elaboration time
  function automatic longint unsigned barrett_m(input int unsigned coef_w, input int unsigned q);
    longint unsigned num;
    num = 64'd1 << (2 * coef_w);
    return num / 64'(q);
  endfunction

endpackage

// File: rtl/mod_mul_barrett.sv
// rtl/mod_mul_barrett.sv - one-lane (a*b) mod Q: product register, then Barrett-reduced output register
module mod_mul_barrett
  import kyber_poly_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int Q      = DEF_Q
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic              en_out,
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [COEF_W-1:0] r
);

  localparam int PW = 2 * COEF_W;
  localparam int TW = 4 * COEF_W;
  localparam logic [PW-1:0] M_C = PW'(barrett_m(COEF_W, Q));
  localparam logic [PW-1:0] Q_C = PW'(Q);

  logic [PW-1:0]     p_q, p_d;
  logic [COEF_W-1:0] r_q, r_d;
  logic [TW-1:0]     pm;
  logic [PW-1:0]     t;
  logic [PW-1:0]     rr;
  logic [PW-1:0]     r1;
  logic [PW-1:0]     r2;

  // product stage and Barrett estimate; t undershoots p/Q by at most two
  always_comb begin
    p_d = en_in ? ({{COEF_W{1'b0}}, a} * {{COEF_W{1'b0}}, b}) : p_q;
    pm  = {{PW{1'b0}}, p_q} * {{PW{1'b0}}, M_C};
    t   = PW'(pm >> PW);
    rr  = p_q - t * Q_C;
    r1  = (rr >= Q_C) ? rr - Q_C : rr;
    r2  = (r1 >= Q_C) ? r1 - Q_C : r1;
    r_d = en_out ? COEF_W'(r2) : r_q;
  end

  // pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      r_q <= '0;
    end else begin
      p_q <= p_d;
      r_q <= r_d;
    end
  end

  assign r = r_q;

endmodule

// File: rtl/poly_pointwise_engine.sv
// rtl/poly_pointwise_engine.sv - streaming lane-wise ADD/SUB/MUL/COPY mod Q over RAM polynomials; POLY_SCALE_EN makes mode 3 a scale by scalar
module poly_pointwise_engine
  import kyber_poly_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int LANES  = DEF_LANES,
  parameter int Q      = DEF_Q,
  parameter int NWORDS = 32,
  parameter int ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [COEF_W-1:0]         scalar,
  input  logic [ADDR_W-1:0]         r_start_offset_A,
  input  logic [ADDR_W-1:0]         r_start_offset_B,
  input  logic [ADDR_W-1:0]         w_data_addr_offset,
  input  logic [LANES*COEF_W-1:0]   r_data,
  output logic [ADDR_W-1:0]         r_data_addr,
  output logic [LANES*COEF_W-1:0]   w_data,
  output logic [ADDR_W-1:0]         w_data_addr,
  output logic                      w_data_en,
  output logic                      busy,
  output logic                      last_cycle
);

  localparam int CNT_W = $clog2(2 * NWORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * NWORDS - 1);
  localparam logic [COEF_W:0]  Q_X      = (COEF_W + 1)'(Q);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d, nxt_cnt;
  logic [1:0]                      mode_q, mode_d;
  logic [ADDR_W-1:0]               off_a_q, off_a_d, off_b_q, off_b_d, off_w_q, off_w_d;
  logic [ADDR_W-1:0]               r_addr_q, r_addr_d;
  logic                            busy_q, busy_d;
  logic [LANES-1:0][COEF_W-1:0]    a_q, a_d;
  logic                            a_v_q, a_v_d, a_last_q, a_last_d;
  logic [LANES-1:0][COEF_W:0]      raw_q, raw_d;
  logic                            s1_v_q, s1_v_d, s1_last_q, s1_last_d;
  logic [LANES-1:0][COEF_W-1:0]    addsub_q, addsub_d;
  logic                            w_en_q, w_en_d, last_q, last_d;
  logic [ADDR_W-1:0]               w_addr_q, w_addr_d, wr_idx_q, wr_idx_d;
  logic [LANES-1:0][COEF_W-1:0]    b_lane, mul_b, mul_r, w_lanes;
  logic                            use_mul;

  assign b_lane = r_data;

  // control FSM: latch the job on start, walk the interleaved A/B read addresses, drain the pipe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    off_a_d  = off_a_q;
    off_b_d  = off_b_q;
    off_w_d  = off_w_q;
    r_addr_d = r_addr_q;
    busy_d   = busy_q;
    nxt_cnt  = cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          cnt_d    = '0;
          mode_d   = mode;
          off_a_d  = r_start_offset_A;
          off_b_d  = r_start_offset_B;
          off_w_d  = w_data_addr_offset;
          r_addr_d = r_start_offset_A;
          busy_d   = 1'b1;
        end
      end
      ST_READ: begin
        cnt_d = nxt_cnt;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DRAIN;
          r_addr_d = '0;
        end else begin
          r_addr_d = (nxt_cnt[0] ? off_b_q : off_a_q) + ADDR_W'(nxt_cnt >> 1);
        end
      end
      ST_DRAIN: begin
        if (last_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // capture A in the cycle after its address; the next cycle carries B
  always_comb begin
    a_d      = a_q;
    a_v_d    = 1'b0;
    a_last_d = 1'b0;
    if (state_q == ST_READ && cnt_q[0]) begin
      a_d      = r_data;
      a_v_d    = 1'b1;
      a_last_d = (cnt_q == CNT_LAST);
    end
  end

  // stage 1: raw sum / difference (borrow in the top bit) while B is on r_data
  always_comb begin
    raw_d     = raw_q;
    s1_v_d    = a_v_q;
    s1_last_d = a_v_q & a_last_q;
    if (a_v_q) begin
      for (int l = 0; l < LANES; l++) begin
        case (mode_q)
          MODE_ADD: raw_d[l] = {1'b0, a_q[l]} + {1'b0, b_lane[l]};
          MODE_SUB: raw_d[l] = {1'b0, a_q[l]} - {1'b0, b_lane[l]};
          default:  raw_d[l] = {1'b0, a_q[l]};
        endcase
      end
    end
  end

  // stage 2: fold add/sub back into [0,Q)
  always_comb begin
    addsub_d = addsub_q;
    if (s1_v_q) begin
      for (int l = 0; l < LANES; l++) begin
        case (mode_q)
          MODE_ADD: addsub_d[l] = (raw_q[l] >= Q_X) ? COEF_W'(raw_q[l] - Q_X) : COEF_W'(raw_q[l]);
          MODE_SUB: addsub_d[l] = raw_q[l][COEF_W] ? COEF_W'(raw_q[l] + Q_X) : COEF_W'(raw_q[l]);
          default:  addsub_d[l] = COEF_W'(raw_q[l]);
        endcase
      end
    end
  end

  // write strobe and address march in step with the reduced data
  always_comb begin
    w_en_d   = s1_v_q;
    last_d   = s1_v_q & s1_last_q;
    w_addr_d = w_addr_q;
    wr_idx_d = wr_idx_q;
    if (state_q == ST_IDLE && start) begin
      wr_idx_d = '0;
    end else if (s1_v_q) begin
      w_addr_d = off_w_q + wr_idx_q;
      wr_idx_d = wr_idx_q + ADDR_W'(1);
    end
  end

`ifdef POLY_SCALE_EN
  logic [COEF_W-1:0] scalar_q, scalar_d;

  // scale constant is held for the whole job
  always_comb begin
    scalar_d = (state_q == ST_IDLE && start) ? scalar : scalar_q;
  end

  // scalar register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scalar_q <= '0;
    else        scalar_q <= scalar_d;
  end

  // multiplier second operand: scalar in mode 3, B otherwise
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      mul_b[l] = (mode_q == MODE_SCALE) ? scalar_q : b_lane[l];
    end
  end
`else
  logic unused_scalar;
  assign unused_scalar = ^scalar;
  assign mul_b         = b_lane;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mod_mul_barrett #(
      .COEF_W (COEF_W),
      .Q      (Q)
    ) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_in  (a_v_q),
      .en_out (s1_v_q),
      .a      (a_q[l]),
      .b      (mul_b[l]),
      .r      (mul_r[l])
    );
  end

  // choose multiplier or add/sub result per job
  always_comb begin
    use_mul = (mode_q == MODE_MUL);
`ifdef POLY_SCALE_EN
    if (mode_q == MODE_SCALE) use_mul = 1'b1;
`endif
    for (int l = 0; l < LANES; l++) begin
      w_lanes[l] = use_mul ? mul_r[l] : addsub_q[l];
    end
  end

  // all state; async reset aborts any job in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      off_a_q   <= '0;
      off_b_q   <= '0;
      off_w_q   <= '0;
      r_addr_q  <= '0;
      busy_q    <= 1'b0;
      a_q       <= '0;
      a_v_q     <= 1'b0;
      a_last_q  <= 1'b0;
      raw_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      addsub_q  <= '0;
      w_en_q    <= 1'b0;
      last_q    <= 1'b0;
      w_addr_q  <= '0;
      wr_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      off_a_q   <= off_a_d;
      off_b_q   <= off_b_d;
      off_w_q   <= off_w_d;
      r_addr_q  <= r_addr_d;
      busy_q    <= busy_d;
      a_q       <= a_d;
      a_v_q     <= a_v_d;
      a_last_q  <= a_last_d;
      raw_q     <= raw_d;
      s1_v_q    <= s1_v_d;
      s1_last_q <= s1_last_d;
      addsub_q  <= addsub_d;
      w_en_q    <= w_en_d;
      last_q    <= last_d;
      w_addr_q  <= w_addr_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  assign r_data_addr = r_addr_q;
  assign w_data      = w_lanes;
  assign w_data_addr = w_addr_q;
  assign w_data_en   = w_en_q;
  assign busy        = busy_q;
  assign last_cycle  = last_q;

endmodule

// File: doc/poly_pointwise_engine.md
Name: poly_pointwise_engine

Overview:
- Streaming coefficient-wise modular arithmetic engine for the Kyber polynomial datapath, sitting beside the NTT processor on the same coefficient RAM port style.
- Reads polynomial A and B word by word from RAM, applies one of ADD, SUB, MUL or COPY/SCALE per lane modulo Q, and writes the result polynomial back.
- It is the parametrised successor of the fixed 8×12-bit MULT/ADDSUB path: lane count, coefficient width, modulus and polynomial length are all generic.

Parameters:
- COEF_W, 12, coefficient width in bits.
- LANES, 8, coefficients per RAM word; RAM word width is LANES*COEF_W.
- Q, 3329, modulus; must satisfy Q < 2^COEF_W.
- NWORDS, 32, RAM words per polynomial.
- ADDR_W, 8, RAM address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse; sampled only in IDLE.
- mode  in  2  operation select: 0 ADD, 1 SUB, 2 MUL, 3 COPY/SCALE.
- scalar  in  COEF_W  scale constant for mode 3; used only with SCALE_EN.
- r_start_offset_A  in  ADDR_W  base address of A.
- r_start_offset_B  in  ADDR_W  base address of B.
- w_data_addr_offset  in  ADDR_W  base address of the result.
- r_data  in  LANES*COEF_W  RAM read data; valid one cycle after r_data_addr.
- r_data_addr  out  ADDR_W  RAM read address.
- w_data  out  LANES*COEF_W  RAM write data.
- w_data_addr  out  ADDR_W  RAM write address.
- w_data_en  out  1  RAM write enable.
- busy  out  1  high from the cycle after start is accepted until last_cycle inclusive.
- last_cycle  out  1  one-cycle pulse coincident with the final write.

Behaviour:
- Reset, asynchronous: state goes to IDLE. All outputs are 0.
- Reset mid-operation aborts immediately. No further writes occur. A new start is needed after release.
- FSM states and transitions:
  - IDLE → READ on start. Mode, scalar and the three offsets are latched at this edge.
  - READ: 2*NWORDS cycles.
  - DRAIN: until the last write.
  - DRAIN → IDLE after last_cycle.
- start while busy is ignored, including start asserted in the cycle last_cycle is high.
- Read schedule: let c0 be the first cycle after start is sampled.
  - r_data_addr = offA+k in cycle c0+2k.
  - r_data_addr = offB+k in cycle c0+2k+1.
  - Addresses wrap modulo 2^ADDR_W.
  - In mode 3, B reads are still issued and their data is ignored, to keep timing uniform.
- Pipeline per word k:
  - A data is captured in cycle c0+2k+1.
  - The B data cycle (c0+2k+2) forms the raw result: sum, difference or product.
  - Next stage reduces the raw result.
  - Registered write: w_data_en=1 with w_data_addr=w_offset+k (wrapping) in cycle c0+2k+4.
- Timing:
  - First write is 5 cycles after the start-sampling edge.
  - Writes follow every 2 cycles, and w_data_en is low in between.
  - Final write is in cycle c0+2*NWORDS+2, with last_cycle=1.
- In-place operation (w_offset == offA or offB) is legal: word k is written only after both of its reads.
- Lane arithmetic (inputs in [0,Q)), per lane:
  - ADD: s=a+b; subtract Q if s≥Q.
  - SUB: a−b, adding Q if a<b.
  - MUL: (a*b) mod Q via Barrett reduction, with m=floor(2^(2*COEF_W)/Q), t=(p*m)>>(2*COEF_W), r=p−t*Q, and up to two conditional subtractions of Q. Must equal exact p mod Q for all a,b<Q.
  - COPY: a.
- All results are in [0,Q).
- Inputs ≥Q produce unspecified values but must not hang or alter timing.

Optional Feature:
- Macro: POLY_SCALE_EN.
- Defined: mode 3 = (a*scalar) mod Q through the same multiplier. This is used for INVNTT final scaling, e.g. scalar=3303=128⁻¹ mod 3329.
- Undefined: mode 3 is pure COPY. The scalar port exists but is ignored, and the multiplier operand mux is removed.

Decomposition:
- Package kyber_poly_pkg:
  - mode encoding constants (MODE_ADD/SUB/MUL/SCALE);
  - default Q, COEF_W, LANES;
  - Barrett constant function;
  - FSM state typedef.
- One sub-module mod_mul_barrett, instantiated LANES times: operands a,b → product register → reduced output. Two-cycle latency, aligned to the pipeline above.
- Add/sub reduction stays inline.

Test Plan:
- ADD, all lanes a=3328, b=1 → every result coefficient 0. Also a=1000, b=2000 → 3000.
- SUB, a=0, b=1 → 3328. Also a=5, b=5 → 0.
- MUL:
  - a=17, b=1175 → 1;
  - a=3328, b=3328 → 1;
  - a=0, b=3328 → 0;
  - random 10k pairs match a*b mod 3329.
- Timing with offA=0, offB=64, w_off=128, start at edge E0:
  - r_data_addr alternates 0,64,1,65,…;
  - first w_data_en at E0+5 with w_data_addr=128;
  - writes every 2 cycles;
  - last write at address 159 with last_cycle=1;
  - busy high throughout;
  - second start mid-run ignored.
- Wrap and in-place: offA=w_off=250, offB=10 → reads and writes 250..255 then 0..25; results correct despite overwriting A.
- rst_n low at the 10th write → outputs zero immediately, no further writes; fresh start completes normally. With POLY_SCALE_EN, mode 3, scalar=3303, a=128 → 1.
